arm_mac_iter: RTL and testbench

- Parametrised, multi-cycle multiply-accumulate unit for the ARM core.
- Supports MUL/MLA and the long forms UMULL/UMLAL/SMULL/SMLAL, selected by mode bits.
- Consumes RADIX_BITS of the multiplier per cycle behind a start/done handshake.
- Optionally terminates early when the remaining multiplier bits are zero, so the long-multiply datapath does not sit in the single-cycle critical path.

---
 rtl/arm_mac_iter.sv | 201 ++++++++++++++++++++
 tb/tb_arm_mac_iter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_mac_iter.sv
// -----------------------------------------------------------------------------
// arm_mac_iter
//   Iterative multiply-accumulate unit for the ARM core. Handles MUL/MLA
//   (W-bit result) and UMULL/UMLAL/SMULL/SMLAL (2W-bit result). The
//   multiplier is retired RADIX_BITS per cycle, LSB first. A final cycle
//   applies the signed-multiplier correction and the accumulator, then
//   registers the result and the {N,Z} flags.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start / ready   request handshake; accepted when both are 1
//   busy            operation in progress (ITER or FINAL)
//   done            one-cycle pulse, results valid
//   is_long         1 = 2W result, 0 = W result
//   is_signed       two's-complement operands (long forms only)
//   accumulate      add {acc_hi,acc_lo} (long) or acc_lo (short)
//   op_a, op_b      multiplicand (Rm), multiplier (Rs)
//   acc_lo, acc_hi  accumulator words
//   res_lo, res_hi  result words (res_hi is 0 for short forms)
//   nz              {N,Z} flags of the result
// -----------------------------------------------------------------------------
module arm_mac_iter #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 2,
    parameter int EARLY_OUT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    output logic             busy,
    input  logic             is_long,
    input  logic             is_signed,
    input  logic             accumulate,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [1:0]       nz,
    output logic             done
);

    localparam int N  = WIDTH / RADIX_BITS;
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_reg;
    logic [CW-1:0]     cnt_reg;
    logic [W2-1:0]     mcand_reg;    // extended multiplicand, shifted left each ITER
    logic [WIDTH-1:0]  mplier_reg;   // multiplier, shifted right each ITER
    logic [W2-1:0]     prod_reg;     // running sum of partial products
    logic [WIDTH-1:0]  a_reg;        // original multiplicand for sign correction
    logic [W2-1:0]     acc_reg;      // accumulator, already zeroed if unused
    logic              b_neg_reg;    // signed long op with negative multiplier
    logic              long_reg;
    logic              signed_reg;   // effective signedness (long forms only)
    logic [WIDTH-1:0]  res_lo_reg;
    logic [WIDTH-1:0]  res_hi_reg;
    logic [1:0]        nz_reg;
    logic              ready_reg;
    logic              busy_reg;
    logic              done_reg;

    logic                  accept;
    logic                  eff_signed;
    logic [RADIX_BITS-1:0] digit;
    logic [W2-1:0]         pp_terms [RADIX_BITS];
    logic [W2-1:0]         pp_sum;
    logic [W2-1:0]         prod_next;
    logic [WIDTH-1:0]      mplier_next;
    logic                  last_iter;
    logic [W2-1:0]         corr;
    logic [W2-1:0]         full;

    assign accept     = start && ready_reg;
    assign eff_signed = is_long && is_signed;

    // One shifted copy of the multiplicand per multiplier bit of the digit.
    assign digit = mplier_reg[RADIX_BITS-1:0];
    generate
        for (genvar gi = 0; gi < RADIX_BITS; gi++) begin : g_pp
            assign pp_terms[gi] = digit[gi] ? (mcand_reg << gi) : '0;
        end
    endgenerate

    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            pp_sum = pp_sum + pp_terms[i];
        end
    end

    assign prod_next   = prod_reg + pp_sum;
    assign mplier_next = mplier_reg >> RADIX_BITS;

    // Early-out only for unsigned work: a signed multiplier's high bits still
    // carry weight through the final correction, so it always runs N cycles.
    assign last_iter = (cnt_reg == CW'(N - 1)) ||
                       ((EARLY_OUT != 0) && !signed_reg && (mplier_next == '0));

    // The multiplier was consumed as unsigned. If it was really negative,
    // ext(b) = b - 2^W, so remove ext(a) << W; modulo 2^2W only the low W
    // bits of ext(a) survive that shift.
    assign corr = b_neg_reg ? {a_reg, {WIDTH{1'b0}}} : '0;
    assign full = prod_reg - corr + acc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            prod_reg   <= '0;
            a_reg      <= '0;
            acc_reg    <= '0;
            b_neg_reg  <= 1'b0;
            long_reg   <= 1'b0;
            signed_reg <= 1'b0;
            res_lo_reg <= '0;
            res_hi_reg <= '0;
            nz_reg     <= 2'b00;
            ready_reg  <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        cnt_reg    <= '0;
                        mcand_reg  <= eff_signed ? {{WIDTH{op_a[WIDTH-1]}}, op_a}
                                                 : {{WIDTH{1'b0}}, op_a};
                        mplier_reg <= op_b;
                        prod_reg   <= '0;
                        a_reg      <= op_a;
                        if (!accumulate)
                            acc_reg <= '0;
                        else if (is_long)
                            acc_reg <= {acc_hi, acc_lo};
                        else
                            acc_reg <= {{WIDTH{1'b0}}, acc_lo};
                        b_neg_reg  <= eff_signed && op_b[WIDTH-1];
                        long_reg   <= is_long;
                        signed_reg <= eff_signed;
                        state_reg  <= S_ITER;
                        ready_reg  <= 1'b0;
                        busy_reg   <= 1'b1;
                    end else begin
                        state_reg  <= S_IDLE;
                        ready_reg  <= 1'b1;
                        busy_reg   <= 1'b0;
                    end
                end
                S_ITER: begin
                    prod_reg   <= prod_next;
                    mcand_reg  <= mcand_reg << RADIX_BITS;
                    mplier_reg <= mplier_next;
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (last_iter)
                        state_reg <= S_FINAL;
                end
                S_FINAL: begin
                    res_lo_reg <= full[WIDTH-1:0];
                    if (long_reg) begin
                        res_hi_reg <= full[W2-1:WIDTH];
                        nz_reg     <= {full[W2-1], full == '0};
                    end else begin
                        res_hi_reg <= '0;
                        nz_reg     <= {full[WIDTH-1], full[WIDTH-1:0] == '0};
                    end
                    state_reg <= S_DONE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= S_IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ready  = ready_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;
    assign res_lo = res_lo_reg;
    assign res_hi = res_hi_reg;
    assign nz     = nz_reg;

endmodule

// File: tb/tb_arm_mac_iter.sv
// -----------------------------------------------------------------------------
// tb_arm_mac_iter
//   Bench for arm_mac_iter. Two instances share the inputs: dut0 without
//   early-out, dut1 with it; sel chooses which one receives start and which
//   one's outputs are observed. Expected results and latencies come from a
//   plain 64-bit reference model, queued at issue and popped at done.
// -----------------------------------------------------------------------------
module tb_arm_mac_iter;

    localparam int W = 32;
    localparam int R = 2;
    localparam int N = W / R;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic [1:0]   nz;
        int           lat;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sel = 1'b0;
    logic         is_long = 1'b0;
    logic         is_signed = 1'b0;
    logic         accumulate = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [W-1:0] acc_lo = '0;
    logic [W-1:0] acc_hi = '0;

    logic         start_0, start_1;
    logic         ready_0, ready_1, busy_0, busy_1, done_0, done_1;
    logic [W-1:0] res_lo_0, res_lo_1, res_hi_0, res_hi_1;
    logic [1:0]   nz_0, nz_1;

    logic         ready, busy, done;
    logic [W-1:0] res_lo, res_hi;
    logic [1:0]   nz;

    int errors = 0;
    int checks = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    assign start_0 = start && !sel;
    assign start_1 = start && sel;

    assign ready  = sel ? ready_1  : ready_0;
    assign busy   = sel ? busy_1   : busy_0;
    assign done   = sel ? done_1   : done_0;
    assign res_lo = sel ? res_lo_1 : res_lo_0;
    assign res_hi = sel ? res_hi_1 : res_hi_0;
    assign nz     = sel ? nz_1     : nz_0;

    arm_mac_iter #(.WIDTH(W), .RADIX_BITS(R), .EARLY_OUT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_0), .ready(ready_0), .busy(busy_0),
        .is_long(is_long), .is_signed(is_signed), .accumulate(accumulate),
        .op_a(op_a), .op_b(op_b), .acc_lo(acc_lo), .acc_hi(acc_hi),
        .res_lo(res_lo_0), .res_hi(res_hi_0), .nz(nz_0), .done(done_0)
    );

    arm_mac_iter #(.WIDTH(W), .RADIX_BITS(R), .EARLY_OUT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_1), .ready(ready_1), .busy(busy_1),
        .is_long(is_long), .is_signed(is_signed), .accumulate(accumulate),
        .op_a(op_a), .op_b(op_b), .acc_lo(acc_lo), .acc_hi(acc_hi),
        .res_lo(res_lo_1), .res_hi(res_hi_1), .nz(nz_1), .done(done_1)
    );

    // Reference: direct 64-bit arithmetic plus the expected ITER count.
    function automatic exp_t model(input bit lng, input bit sgn, input bit accm,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] alo, input logic [W-1:0] ahi,
                                   input bit eo, input string name);
        exp_t e;
        logic [2*W-1:0] ea, eb, acc, full;
        bit s;
        int k;
        s    = lng && sgn;
        ea   = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb   = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        acc  = !accm ? '0 : (lng ? {ahi, alo} : {{W{1'b0}}, alo});
        full = ea * eb + acc;
        e.lo = full[W-1:0];
        if (lng) begin
            e.hi = full[2*W-1:W];
            e.nz = {full[2*W-1], full == '0};
        end else begin
            e.hi = '0;
            e.nz = {full[W-1], full[W-1:0] == '0};
        end
        k = N;
        if (eo && !s) begin
            k = 1;
            while (k < N && (b >> (R * k)) != '0) k++;
        end
        e.lat  = k + 2;
        e.name = name;
        return e;
    endfunction

    // Called between a negedge and the next posedge; accepts on that posedge,
    // then scrambles the inputs so the latched operands are what count.
    task automatic issue(input bit lng, input bit sgn, input bit accm,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] alo, input logic [W-1:0] ahi,
                         input string name);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_at_issue: got %b want 1", name, ready);
        end
        sb_q.push_back(model(lng, sgn, accm, a, b, alo, ahi, sel, name));
        is_long = lng; is_signed = sgn; accumulate = accm;
        op_a = a; op_b = b; acc_lo = alo; acc_hi = ahi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        is_long = $urandom_range(0, 1); is_signed = $urandom_range(0, 1);
        accumulate = $urandom_range(0, 1);
        op_a = $urandom; op_b = $urandom; acc_lo = $urandom; acc_hi = $urandom;
    endtask

    // Returns at the negedge of the done cycle (or after a bounded timeout).
    task automatic wait_done();
        exp_t e;
        int c;
        e = sb_q.pop_front();
        c = 1;
        forever begin
            @(negedge clk);
            if (done === 1'b1) break;
            checks++;
            if (busy !== 1'b1 || ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy_c%0d: got busy=%b ready=%b want busy=1 ready=0",
                         e.name, c, busy, ready);
            end
            c++;
            if (c > 60) begin
                errors++;
                $display("FAIL %s_timeout: no done within 60 cycles", e.name);
                return;
            end
        end
        checks++;
        if (c !== e.lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d want %0d", e.name, c, e.lat);
        end
        checks++;
        if (res_lo !== e.lo) begin
            errors++;
            $display("FAIL %s_res_lo: got %h want %h", e.name, res_lo, e.lo);
        end
        checks++;
        if (res_hi !== e.hi) begin
            errors++;
            $display("FAIL %s_res_hi: got %h want %h", e.name, res_hi, e.hi);
        end
        checks++;
        if (nz !== e.nz) begin
            errors++;
            $display("FAIL %s_nz: got %b want %b", e.name, nz, e.nz);
        end
        checks++;
        if (busy !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_state: got busy=%b ready=%b want busy=0 ready=1",
                     e.name, busy, ready);
        end
        $display("txn %s: cycles=%0d res_hi=%h res_lo=%h nz=%b", e.name, c, res_hi, res_lo, nz);
    endtask

    task automatic run_op(input bit lng, input bit sgn, input bit accm,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] alo, input logic [W-1:0] ahi,
                          input string name);
        @(negedge clk);
        issue(lng, sgn, accm, a, b, alo, ahi, name);
        wait_done();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b busy=%b done=%b want 1 0 0", ready, busy, done);
        end
        checks++;
        if (res_lo !== '0 || res_hi !== '0 || nz !== 2'b00) begin
            errors++;
            $display("FAIL reset_res: got %h %h nz=%b want zeros", res_hi, res_lo, nz);
        end
        $display("txn reset: ready=%b busy=%b", ready, busy);
    endtask

    task automatic test_short_mul();
        logic [W-1:0] held;
        sel = 1'b0;
        run_op(1'b0, 1'b0, 1'b0, 32'd7, 32'd6, 32'd0, 32'd0, "mul_7x6");
        held = res_lo;
        repeat (3) @(negedge clk);
        checks++;
        if (res_lo !== held || done !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_after_done: got res_lo=%h done=%b ready=%b want %h 0 1",
                     res_lo, done, ready, held);
        end
    endtask

    task automatic test_long();
        sel = 1'b0;
        run_op(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, "smull_m1x2");
        run_op(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, "umlal_max");
        run_op(1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, "smlal_min");
        run_op(1'b1, 1'b1, 1'b0, 32'd12345, 32'hFFFF_FFF0, 32'd0, 32'd0, "smull_pos_neg");
        for (int i = 0; i < 4; i++) begin
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom, $urandom, $sformatf("rand_%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        run_op(1'b0, 1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, "mla_wrap");
        // Still in the DONE cycle: issue the next op right here.
        issue(1'b0, 1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0, "b2b_3x5");
        wait_done();
    endtask

    task automatic test_early_out();
        sel = 1'b1;
        run_op(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'd3, 32'd0, 32'd0, "eo_b3");
        run_op(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0, "eo_b0");
        run_op(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd9, 32'd1, "eo_bmsb");
        run_op(1'b1, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd3, 32'd0, 32'd0, "eo_signed");
        for (int i = 0; i < 4; i++) begin
            run_op(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom,
                   $urandom >> $urandom_range(0, 31), $urandom, $urandom,
                   $sformatf("eo_rand_%0d", i));
        end
        sel = 1'b0;
    endtask

    task automatic test_abort();
        bit seen;
        sel = 1'b0;
        @(negedge clk);
        is_long = 1'b1; is_signed = 1'b0; accumulate = 1'b1;
        op_a = 32'h0BAD_F00D; op_b = 32'h1357_9BDF; acc_lo = 32'd1; acc_hi = 32'd2;
        start = 1'b1;
        @(posedge clk);                       // cycle 0: accepted
        for (int i = 1; i <= 4; i++) begin    // cycles 1..4: start held, operands change
            #1;
            op_a = $urandom; op_b = $urandom;
            @(posedge clk);
        end
        #1;                                   // cycle 5: reset
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ctrl: got busy=%b ready=%b want 0 1", busy, ready);
        end
        checks++;
        if (res_lo !== '0 || res_hi !== '0 || nz !== 2'b00) begin
            errors++;
            $display("FAIL abort_res: got %h %h nz=%b want zeros", res_hi, res_lo, nz);
        end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got done pulse want none");
        end
        $display("txn abort: busy=%b ready=%b done_seen=%b", busy, ready, seen);
    endtask

    initial begin
        test_reset();
        test_short_mul();
        test_long();
        test_back_to_back();
        test_early_out();
        test_abort();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d left want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
